serial_bank_loader: RTL

Bit-serial loader that feeds a bank of WIDTH one-bit enabled registers (clk/rst/write_en/data_in/data_out cells). It accepts a start pulse, then consumes WIDTH serial bits under a valid handshake. Each accepted bit is steered to exactly one register cell via a one-hot write-enable vector. It sits directly upstream of the register bank and signals completion with a one-cycle done pulse.

---
 rtl/serial_bank_loader.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_bank_loader.sv
// Bit-serial loader that steers WIDTH accepted bits into a bank of one-bit
// enabled register cells through a one-hot write enable, then pulses done.
module serial_bank_loader #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       serial_valid,
    input  logic                       serial_in,
    output logic                       serial_ready,
    output logic                       data_in,
    output logic [WIDTH-1:0]           write_en,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] bit_count
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             accept;

    function automatic logic [IDX_W-1:0] target_cell(input logic [IDX_W-1:0] i);
        if (MSB_FIRST != 0)
            return LAST_IDX - i;
        else
            return i;
    endfunction

    function automatic logic [WIDTH-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [WIDTH-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // write_en and data_in are combinational from serial_valid/serial_in so a
    // bit is captured by its cell on the same edge that accepts it.
    assign accept       = (state == LOAD) && serial_valid;
    assign data_in      = serial_in;
    assign write_en     = accept ? onehot(target_cell(idx)) : '0;

    assign serial_ready = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign bit_count    = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        idx     <= '0;
                        cnt     <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (serial_valid) begin
                        cnt <= cnt + CNT_W'(1);
                        if (idx == LAST_IDX) begin
                            state   <= DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    // bit_count is left at WIDTH until the next start clears it
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    a_we_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(write_en));
    a_we_only_load: assert property (@(posedge clk) disable iff (rst)
        (state != LOAD) |-> (write_en == '0));

endmodule
